// File: rtl/hazard_pipe_ctrl.sv
// EX/MEM and MEM/WB destination/result registers for operand forwarding,
// plus stall/flush generation for load-use, taken branches and slow data memory.
module hazard_pipe_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_e,
  input  logic             register_write_e,
  input  logic             mem_read_e,
  input  logic [1:0]       result_src_e,
  input  logic [XLEN-1:0]  alu_result_e,
  input  logic [XLEN-1:0]  pc_plus4_e,
  input  logic             pc_src_e,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ready,
  output logic [4:0]       rd_mem,
  output logic             register_write_mem,
  output logic             mem_read_mem,
  output logic [XLEN-1:0]  alu_result_mem,
  output logic [4:0]       rd_wb,
  output logic             register_write_wb,
  output logic [XLEN-1:0]  result_wb,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             stall_e,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]      result_src_mem;
  logic            mem_wait;
  logic            load_use;
  logic            load_use_stall;
  logic [XLEN-1:0] ex_value;

  assign mem_wait = mem_read_mem & ~dmem_ready;
  assign load_use = mem_read_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
  // A redirect makes the ID instruction wrong-path, so its load-use stall is moot.
  assign load_use_stall = ~mem_wait & ~pc_src_e & load_use;
  assign ex_value = (result_src_e == 2'b10) ? pc_plus4_e : alu_result_e;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_mem             <= '0;
      register_write_mem <= 1'b0;
      mem_read_mem       <= 1'b0;
      result_src_mem     <= '0;
      alu_result_mem     <= '0;
    end else if (!mem_wait) begin
      rd_mem             <= rd_e;
      register_write_mem <= register_write_e;
      mem_read_mem       <= mem_read_e;
      result_src_mem     <= result_src_e;
      alu_result_mem     <= ex_value;
    end
  end

  // While waiting, WB receives a bubble; rd_wb/result_wb keep their old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wb             <= '0;
      register_write_wb <= 1'b0;
      result_wb         <= '0;
    end else if (mem_wait) begin
      register_write_wb <= 1'b0;
    end else begin
      rd_wb             <= rd_mem;
      register_write_wb <= register_write_mem;
      result_wb         <= (result_src_mem == 2'b01) ? dmem_rdata : alu_result_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_cnt <= '0;
      mem_wait_cnt <= '0;
    end else begin
      if (load_use_stall && load_use_cnt != CNT_MAX)
        load_use_cnt <= load_use_cnt + 1'b1;
      if (mem_wait && mem_wait_cnt != CNT_MAX)
        mem_wait_cnt <= mem_wait_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural pipeline model.
module tb_hazard_pipe_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_e = '0;
  logic register_write_e = 1'b0, mem_read_e = 1'b0, pc_src_e = 1'b0, dmem_ready = 1'b1;
  logic [1:0] result_src_e = '0;
  logic [XLEN-1:0] alu_result_e = '0, pc_plus4_e = '0, dmem_rdata = '0;
  logic [4:0] rd_mem, rd_wb;
  logic register_write_mem, mem_read_mem, register_write_wb;
  logic [XLEN-1:0] alu_result_mem, result_wb;
  logic stall_f, stall_d, flush_d, flush_e, stall_e;
  logic [CNT_W-1:0] load_use_cnt, mem_wait_cnt;

  int chk_cnt = 0;
  int pass_cnt = 0;

  hazard_pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .register_write_e(register_write_e), .mem_read_e(mem_read_e),
    .result_src_e(result_src_e), .alu_result_e(alu_result_e), .pc_plus4_e(pc_plus4_e),
    .pc_src_e(pc_src_e), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .rd_mem(rd_mem), .register_write_mem(register_write_mem), .mem_read_mem(mem_read_mem),
    .alu_result_mem(alu_result_mem), .rd_wb(rd_wb), .register_write_wb(register_write_wb),
    .result_wb(result_wb), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .stall_e(stall_e), .load_use_cnt(load_use_cnt),
    .mem_wait_cnt(mem_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the instruction sitting in MEM and in WB, plus event tallies.
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic [1:0]  src;
    logic [31:0] val;
  } slot_t;

  slot_t m_mem = '{rd: 0, we: 0, ld: 0, src: 0, val: 0};
  slot_t m_wb  = '{rd: 0, we: 0, ld: 0, src: 0, val: 0};
  int m_lu_cnt = 0;
  int m_mw_cnt = 0;

  function automatic bit hazard_lu();
    return mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
  endfunction

  function automatic bit waiting();
    return m_mem.ld && !dmem_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mem = '{rd: 0, we: 0, ld: 0, src: 0, val: 0};
      m_wb  = '{rd: 0, we: 0, ld: 0, src: 0, val: 0};
      m_lu_cnt = 0;
      m_mw_cnt = 0;
    end else if (waiting()) begin
      m_mw_cnt = (m_mw_cnt < CMAX) ? m_mw_cnt + 1 : CMAX;
      m_wb.we = 1'b0;
    end else begin
      if (!pc_src_e && hazard_lu()) m_lu_cnt = (m_lu_cnt < CMAX) ? m_lu_cnt + 1 : CMAX;
      m_wb.rd  = m_mem.rd;
      m_wb.we  = m_mem.we;
      m_wb.val = (m_mem.src == 2'b01) ? dmem_rdata : m_mem.val;
      m_mem.rd  = rd_e;
      m_mem.we  = register_write_e;
      m_mem.ld  = mem_read_e;
      m_mem.src = result_src_e;
      m_mem.val = (result_src_e == 2'b10) ? pc_plus4_e : alu_result_e;
    end
  end

  always @(negedge clk) begin
    bit w, br, lu;
    w  = waiting();
    br = !w && pc_src_e;
    lu = !w && !pc_src_e && hazard_lu();
    chk("m_rd_mem", 32'(rd_mem), 32'(m_mem.rd));
    chk("m_register_write_mem", 32'(register_write_mem), 32'(m_mem.we));
    chk("m_mem_read_mem", 32'(mem_read_mem), 32'(m_mem.ld));
    chk("m_alu_result_mem", alu_result_mem, m_mem.val);
    chk("m_rd_wb", 32'(rd_wb), 32'(m_wb.rd));
    chk("m_register_write_wb", 32'(register_write_wb), 32'(m_wb.we));
    chk("m_result_wb", result_wb, m_wb.val);
    chk("m_stall_f", 32'(stall_f), 32'(w || lu));
    chk("m_stall_d", 32'(stall_d), 32'(w || lu));
    chk("m_stall_e", 32'(stall_e), 32'(w));
    chk("m_flush_d", 32'(flush_d), 32'(br));
    chk("m_flush_e", 32'(flush_e), 32'(br || lu));
    chk("m_load_use_cnt", 32'(load_use_cnt), 32'(m_lu_cnt));
    chk("m_mem_wait_cnt", 32'(mem_wait_cnt), 32'(m_mw_cnt));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rd_e = 0; register_write_e = 0; mem_read_e = 0;
    result_src_e = 0; alu_result_e = 0; pc_plus4_e = 0; pc_src_e = 0; dmem_ready = 1;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    idle();
    rd_e = rd; mem_read_e = 1; register_write_e = 1; result_src_e = 2'b01;
  endtask

  initial begin
    // Reset holds everything at zero despite active EX inputs.
    idle();
    register_write_e = 1; rd_e = 5; alu_result_e = 32'h55;
    @(negedge clk);
    chk("rst_rd_mem", 32'(rd_mem), 0);
    chk("rst_wb_we", 32'(register_write_wb), 0);
    chk("rst_result_wb", result_wb, 0);
    rst_n = 1;
    cyc(); idle();
    @(negedge clk);
    chk("rel_rd_mem", 32'(rd_mem), 5);
    chk("rel_wb_we_early", 32'(register_write_wb), 0);
    cyc(); @(negedge clk);
    chk("rel_rd_wb", 32'(rd_wb), 5);
    chk("rel_wb_we", 32'(register_write_wb), 1);
    chk("rel_result_wb", result_wb, 32'h55);

    // Load-use: one bubble, counted once; rd=0 never stalls.
    cyc(); ex_load(7); rs1_d = 7;
    @(negedge clk);
    chk("lu_stall_f", 32'(stall_f), 1);
    chk("lu_stall_d", 32'(stall_d), 1);
    chk("lu_flush_e", 32'(flush_e), 1);
    chk("lu_stall_e", 32'(stall_e), 0);
    cyc(); idle(); rs1_d = 7;
    @(negedge clk);
    chk("lu_released", 32'(stall_f), 0);
    chk("lu_cnt_1", 32'(load_use_cnt), 1);
    cyc(); idle(); mem_read_e = 1;
    @(negedge clk);
    chk("lu_rd0_stall", 32'(stall_f), 0);
    chk("lu_rd0_flush", 32'(flush_e), 0);

    // Three-cycle memory wait, then data 0xDEADBEEF.
    cyc(); ex_load(9);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); dmem_ready = 0;
      @(negedge clk);
      chk("mw_stall_f", 32'(stall_f), 1);
      chk("mw_stall_e", 32'(stall_e), 1);
      chk("mw_wb_we", 32'(register_write_wb), 0);
    end
    chk("mw_rd_mem_held", 32'(rd_mem), 9);
    cyc(); idle(); dmem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("mw_done_stall", 32'(stall_f), 0);
    cyc(); idle();
    @(negedge clk);
    chk("mw_result_wb", result_wb, 32'hDEADBEEF);
    chk("mw_rd_wb", 32'(rd_wb), 9);
    chk("mw_wb_we", 32'(register_write_wb), 1);
    chk("mw_cnt_3", 32'(mem_wait_cnt), 3);

    // Branch beats load-use.
    cyc(); ex_load(7); rs2_d = 7; pc_src_e = 1;
    @(negedge clk);
    chk("br_flush_d", 32'(flush_d), 1);
    chk("br_flush_e", 32'(flush_e), 1);
    chk("br_stall_f", 32'(stall_f), 0);
    chk("br_stall_d", 32'(stall_d), 0);
    cyc(); idle();
    @(negedge clk);
    chk("br_lu_cnt", 32'(load_use_cnt), 1);

    // Branch held off by a memory wait.
    cyc(); ex_load(10);
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); pc_src_e = 1; dmem_ready = 0;
      @(negedge clk);
      chk("bw_no_flush_d", 32'(flush_d), 0);
      chk("bw_no_flush_e", 32'(flush_e), 0);
      chk("bw_stall_f", 32'(stall_f), 1);
    end
    cyc(); idle(); pc_src_e = 1;
    @(negedge clk);
    chk("bw_flush_d", 32'(flush_d), 1);
    chk("bw_flush_e", 32'(flush_e), 1);
    chk("bw_stall_f_off", 32'(stall_f), 0);
    chk("bw_mw_cnt", 32'(mem_wait_cnt), 5);

    // pc+4 result select.
    cyc(); idle(); rd_e = 4; register_write_e = 1; result_src_e = 2'b10;
    pc_plus4_e = 32'h104; alu_result_e = 32'h999;
    cyc(); idle();
    @(negedge clk);
    chk("sel_alu_result_mem", alu_result_mem, 32'h104);
    cyc(); @(negedge clk);
    chk("sel_result_wb", result_wb, 32'h104);

    // Saturate the load-use counter.
    cyc(); ex_load(7); rs1_d = 7;
    repeat (CMAX + 4) cyc();
    @(negedge clk);
    chk("sat_lu_cnt", 32'(load_use_cnt), 32'hFFFF);
    repeat (3) cyc();
    @(negedge clk);
    chk("sat_lu_hold", 32'(load_use_cnt), 32'hFFFF);

    // Reset in the middle of a wait drops mem_wait at once.
    cyc(); ex_load(3);
    cyc(); idle(); dmem_ready = 0;
    @(negedge clk);
    chk("rw_waiting", 32'(stall_f), 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rw_mem_read_mem", 32'(mem_read_mem), 0);
    chk("rw_stall_f", 32'(stall_f), 0);
    chk("rw_lu_cnt", 32'(load_use_cnt), 0);
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic; small register indices make hazards frequent.
    repeat (3000) begin
      cyc();
      rs1_d = 5'($urandom_range(0, 7));
      rs2_d = 5'($urandom_range(0, 7));
      rd_e = 5'($urandom_range(0, 7));
      register_write_e = 1'($urandom_range(0, 1));
      mem_read_e = ($urandom_range(0, 9) < 3);
      result_src_e = 2'($urandom_range(0, 3));
      alu_result_e = $urandom;
      pc_plus4_e = $urandom;
      pc_src_e = ($urandom_range(0, 9) < 2);
      dmem_rdata = $urandom;
      dmem_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_pipe_ctrl.md
Name: hazard_pipe_ctrl

Overview:
Producer side of the operand-forwarding interface. Owns the EX/MEM and MEM/WB destination/result pipeline registers that supply rd_mem, rd_wb, register_write_mem, register_write_wb and the forwarded data values. Also generates the stall and flush controls that forwarding cannot cover:
- load-use hazards
- taken-branch redirects
- variable-latency data-memory waits
Sits between the EX stage outputs and the register-file write port; the rs1/rs2 forwarding muxes consume its outputs.

Parameters:
XLEN, 32, datapath width of result registers
CNT_W, 16, width of the saturating stall performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs1_d  in  5  rs1 of instruction in ID
rs2_d  in  5  rs2 of instruction in ID
rd_e  in  5  destination of instruction in EX
register_write_e  in  1  EX instruction writes rd
mem_read_e  in  1  EX instruction is a load
result_src_e  in  2  00 ALU, 01 load data, 10 pc+4
alu_result_e  in  XLEN  ALU result in EX
pc_plus4_e  in  XLEN  pc+4 of EX instruction
pc_src_e  in  1  taken branch/jump resolved in EX
dmem_rdata  in  XLEN  data memory read data, valid when dmem_ready=1
dmem_ready  in  1  data memory completes the MEM-stage access this cycle
rd_mem  out  5  destination in MEM
register_write_mem  out  1  MEM writes rd
mem_read_mem  out  1  MEM holds a load (drives dmem request)
alu_result_mem  out  XLEN  forwardable value from MEM
rd_wb  out  5  destination in WB
register_write_wb  out  1  WB writes rd (register-file write enable)
result_wb  out  XLEN  selected writeback value
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register (insert bubble)
stall_e  out  1  hold ID/EX register
load_use_cnt  out  CNT_W  saturating count of load-use stall cycles
mem_wait_cnt  out  CNT_W  saturating count of memory-wait cycles

Behaviour:
- Reset (async, rst_n=0): all registered outputs are 0 (rd_mem, register_write_mem, mem_read_mem, alu_result_mem, rd_wb, register_write_wb, result_wb, both counters); no spurious write enable when reset is released.
- EX/MEM register:
  - on each clk edge unless mem_wait=1, captures rd_e, register_write_e, mem_read_e, result_src_e, alu_result_e, pc_plus4_e.
  - alu_result_mem = alu_result_e when result_src_e=00, pc_plus4_e when 10, alu_result_e otherwise.
- mem_wait = mem_read_mem & ~dmem_ready (combinational).
- MEM/WB register:
  - if mem_wait: register_write_wb<=0 (bubble); rd_wb and result_wb are don't-care but hold their values.
  - else: rd_wb<=rd_mem; register_write_wb<=register_write_mem; result_wb<=dmem_rdata if MEM result_src=01, else alu_result_mem.
  - latency EX->WB is 2 cycles plus wait cycles.
- Load-use hazard: lu = mem_read_e & (rd_e!=0) & (rd_e==rs1_d | rd_e==rs2_d).
- Control priority, highest first:
  1. mem_wait=1: stall_f=stall_d=stall_e=1, flush_d=flush_e=0, pc_src_e ignored (EX is frozen, so the branch is re-evaluated after the wait).
  2. pc_src_e=1: flush_d=flush_e=1, stalls 0. lu is suppressed because the ID instruction is wrong-path.
  3. lu=1: stall_f=stall_d=1, flush_e=1, stall_e=0. Exactly one bubble; next cycle the load is in MEM and data is forwarded from WB after completion.
  4. Otherwise: all controls 0.
- Counters:
  - load_use_cnt increments on cycles where case 3 is active.
  - mem_wait_cnt increments on cycles where mem_wait=1.
  - both saturate at all-ones, no wrap.
- Zero-latency memory: when dmem_ready=1 in the first MEM cycle of a load, no wait cycle is produced.
- Reset mid-wait clears mem_read_mem, so mem_wait deasserts immediately.

Test Plan:
1. Reset: hold rst_n=0 while driving register_write_e=1, rd_e=5 -> all outputs 0; release -> rd_mem=5 one edge later, rd_wb=5 two edges later, register_write_wb=1.
2. Load-use: lw with rd_e=7, mem_read_e=1, rs1_d=7 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; load_use_cnt=1. Same with rd_e=0 -> no stall.
3. Memory wait: load reaches MEM with dmem_ready=0 for 3 cycles, then 1 with dmem_rdata=0xDEADBEEF -> stall_f/d/e=1 for 3 cycles; register_write_wb=0 during the wait; result_wb=0xDEADBEEF one edge after ready; mem_wait_cnt=3.
4. Branch vs load-use: pc_src_e=1 with lu=1 -> flush_d=flush_e=1, stall_f=stall_d=0, load_use_cnt unchanged.
5. Branch during wait: pc_src_e=1 while mem_wait=1 -> no flush until dmem_ready=1; flush_d=flush_e=1 in the first cycle after the wait.
6. Result select: result_src_e=10, pc_plus4_e=0x104 -> alu_result_mem=0x104, then result_wb=0x104. Also hold load_use_cnt at 0xFFFF with further load-use stalls -> counter remains 0xFFFF.
